// File: rtl/dp_ctrl_pkg.sv
// Shared types, widths and mode thresholds for the datapath request scheduler.
package dp_ctrl_pkg;

  localparam int A_W = 10;
  localparam int C_W = 9;
  localparam int R_W = 11;

  localparam int MODE_T0 = 51;
  localparam int MODE_T1 = 100;
  localparam int MODE_T2 = 128;

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;
  typedef enum logic [1:0] {MODE_CLKDIV, MODE_SHIFT, MODE_PARITY, MODE_LFSR} mode_t;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [C_W-1:0] c;
  } op_t;

  function automatic mode_t mode_of(input logic [C_W-1:0] c);
    if (int'(c) < MODE_T0) return MODE_CLKDIV;
    if (int'(c) < MODE_T1) return MODE_SHIFT;
    if (int'(c) <= MODE_T2) return MODE_PARITY;
    return MODE_LFSR;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first request at or after ptr, wrapping modulo NREQ.
// Latency: combinational.
// Backpressure: none; grant is purely a function of req and ptr.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [NREQ-1:0]   lo_mask;
  logic [2*NREQ-1:0] dbl;
  logic              found;

  // Lower copy only sees requests at/after ptr; upper copy supplies the wrap.
  always_comb begin
    lo_mask = '0;
    for (int i = 0; i < NREQ; i++) lo_mask[i] = (i >= int'(ptr));
    dbl   = {req, req & lo_mask};
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < 2*NREQ; j++) begin
      if (!found && dbl[j]) begin
        found             = 1'b1;
        grant[j % NREQ]   = 1'b1;
        idx               = IDW'(j % NREQ);
      end
    end
    any = |req;
  end

endmodule

// File: rtl/dp_req_scheduler.sv
// Shares one fixed-latency datapath among NREQ requesters with round-robin grants.
// Latency: accept at T, dp_start at T+1, response valid from T+LAT+1.
// Backpressure: one transaction in flight; response held stable until rsp_ready.
module dp_req_scheduler
  import dp_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*A_W-1:0]  req_a,
  input  logic [NREQ*C_W-1:0]  req_c,
  input  logic [NREQ-1:0]      req_mask,
  output logic [A_W-1:0]       dp_a,
  output logic [C_W-1:0]       dp_c,
  output logic                 dp_start,
  input  logic [R_W-1:0]       dp_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [1:0]           rsp_mode,
  output logic [R_W-1:0]       rsp_data,
  output logic                 busy
);

  localparam int CNTW = $clog2(LAT + 2);

  if (LAT < 1 || NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ)) begin : g_bad_param
    $error("dp_req_scheduler: illegal LAT/NREQ/IDW combination");
  end

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, id_q, win_idx;
  logic [NREQ-1:0] win_gnt;
  logic            win_any, accept, last;
  logic [CNTW-1:0] cnt;
  op_t             op_q;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid & req_mask),
    .ptr   (ptr),
    .grant (win_gnt),
    .idx   (win_idx),
    .any   (win_any)
  );

  // cnt is loaded with LAT and the result is sampled on the edge where it falls to 1.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_any && !rst) begin
          req_ready = win_gnt;
          accept    = 1'b1;
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        last      = (LAT == 1);
        state_nxt = (LAT == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == CNTW'(2)) begin
          last      = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      op_q     <= '0;
      id_q     <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q.a <= req_a[int'(win_idx)*A_W +: A_W];
        op_q.c <= req_c[int'(win_idx)*C_W +: C_W];
        id_q   <= win_idx;
      end
      if (state == ST_LAUNCH) cnt <= CNTW'(LAT);
      else if (state == ST_WAIT) cnt <= cnt - 1'b1;
      if (last) rsp_data <= dp_result;
      // The requester just served drops to lowest priority.
      if (state == ST_RESP && rsp_ready)
        ptr <= (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
    end
  end

  assign dp_a      = op_q.a;
  assign dp_c      = op_q.c;
  assign dp_start  = (state == ST_LAUNCH);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign rsp_id    = id_q;
  assign rsp_mode  = mode_of(op_q.c);

endmodule
